cond_logic: RTL and testbench
=============================

// Module: cond_logic
// PURPOSE
// - Conditional-execution unit directly downstream of the main decoder in the single-cycle ARM datapath.
// - Holds the architectural NZCV flag register and evaluates Instr[31:28] against it.
// - Gates the decoder's PCS/RegW/MemW into the final PCSrc/RegWrite/MemWrite.
// - Updates the flags from the ALU when the decoder's FlagW requests it and the instruction executes.
// PARAMETERS
// - CNT_W  32  width of the perf counters (used only with COND_LOGIC_PERF_EN)
// PORTS
// - clk        in   1      system clock; all state updates on rising edge
// - reset      in   1      synchronous, active-high reset
// - Cond       in   4      condition field, Instr[31:28]
// - ALUFlags   in   4      {N,Z,C,V} from the ALU for the current instruction
// - FlagW      in   2      decoder flag-write request; [1]=N,Z  [0]=C,V
// - PCS        in   1      decoder: instruction writes PC (branch or Rd=15)
// - RegW       in   1      decoder: register-file write request
// - MemW       in   1      decoder: data-memory write request
// - PCSrc      out  1      PCS & CondEx
// - RegWrite   out  1      RegW & CondEx
// - MemWrite   out  1      MemW & CondEx
// - Flags      out  4      current registered {N,Z,C,V}, for debug/bench visibility
// - CondEx     out  1      condition passed this cycle
// - ExecCnt    out  CNT_W  [PERF only] count of executed instructions
// - SquashCnt  out  CNT_W  [PERF only] count of squashed instructions
// BEHAVIOUR
// - Reset: Flags=4'b0000; counters=0.
//   - While reset=1, PCSrc, RegWrite, MemWrite and CondEx are forced to 0 (no spurious architectural writes).
// - CondEx: combinational, from *registered* Flags, never from ALUFlags (same-cycle, zero latency).
// - Condition table:
//   - 0000 EQ Z         0001 NE !Z        0010 CS C         0011 CC !C
//   - 0100 MI N         0101 PL !N        0110 VS V         0111 VC !V
//   - 1000 HI C&!Z      1001 LS !C|Z      1010 GE N==V      1011 LT N!=V
//   - 1100 GT !Z&(N==V) 1101 LE Z|(N!=V)  1110 AL 1         1111 reserved -> 0 (never execute)
// - Flag update at rising clk, when reset=0:
//   - FlagW[1]&CondEx: {N,Z} <= ALUFlags[3:2]
//   - FlagW[0]&CondEx: {C,V} <= ALUFlags[1:0]
//   - Halves update independently; FlagW=00 or CondEx=0 holds both halves.
// - A flag write becomes visible to CondEx from the next cycle only. There is no bypass: a conditional instruction directly after a flag setter sees the new flags, never the old.
// - Reset asserted in the same cycle as a flag write: reset wins, Flags=0000.
// - Outputs PCSrc/RegWrite/MemWrite: pure AND of decoder request and CondEx; no added latency.
// CONFIGURATION
// - COND_LOGIC_PERF_EN defined:
//   - ExecCnt and SquashCnt ports exist.
//   - Each non-reset cycle increments exactly one counter: ExecCnt if CondEx=1, else SquashCnt.
//   - Counters saturate at all-ones (no wrap) and clear on reset.
// - COND_LOGIC_PERF_EN undefined: counter ports and logic are absent; all other behaviour is identical.
// TESTING
// - Reset: reset=1, Cond=1110, PCS=RegW=MemW=1 -> PCSrc=RegWrite=MemWrite=0, Flags=0000; release -> all three =1.
// - Flag set: Cond=1110, FlagW=11, ALUFlags=0100 -> Flags=0100 next cycle; then Cond=0000 (EQ), RegW=1 -> RegWrite=1; Cond=0001 -> RegWrite=0.
// - Partial update: Flags=0100, FlagW=01, ALUFlags=1011 -> Flags=0111 (N,Z kept, C,V taken).
// - Squashed setter: Flags=0000, Cond=0000, FlagW=11, ALUFlags=1111 -> Flags stay 0000; MemW=1 -> MemWrite=0.
// - Signed conditions: Flags=1001 (N=V=1) -> GE=1, LT=0, GT=1, LE=0; Flags=1000 -> GE=0, LT=1, LE=1; Cond=1111 -> CondEx=0.
// - PERF (COND_LOGIC_PERF_EN, CNT_W=4):
//   - 5 cycles AL + 3 cycles NE with Z=1 -> ExecCnt=5, SquashCnt=3.
//   - 20 cycles AL -> ExecCnt saturates at 15.
//   - reset -> both counters 0.

Source files
------------

// File: rtl/cond_logic.sv
// Conditional-execution unit: holds NZCV, evaluates Cond against it, and gates PCS/RegW/MemW.
// Latency: CondEx and gated writes are combinational; flag updates take effect from the next cycle.
// No backpressure; optional perf counters are enabled with COND_LOGIC_PERF_EN.
module cond_logic #(
    parameter int CNT_W = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Cond,
    input  logic [3:0] ALUFlags,
    input  logic [1:0] FlagW,
    input  logic       PCS,
    input  logic       RegW,
    input  logic       MemW,
    output logic       PCSrc,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic [3:0] Flags,
    output logic       CondEx
`ifdef COND_LOGIC_PERF_EN
    ,
    output logic [CNT_W-1:0] ExecCnt,
    output logic [CNT_W-1:0] SquashCnt
`endif
);

    logic [3:0] r_flags;
    logic       w_n;
    logic       w_z;
    logic       w_c;
    logic       w_v;
    logic       w_cond_pass;

    assign {w_n, w_z, w_c, w_v} = r_flags;

    // Evaluate the condition field against the registered flags only (ALUFlags never bypass).
    always_comb begin
        w_cond_pass = 1'b0;
        case (Cond)
            4'b0000: w_cond_pass = w_z;
            4'b0001: w_cond_pass = ~w_z;
            4'b0010: w_cond_pass = w_c;
            4'b0011: w_cond_pass = ~w_c;
            4'b0100: w_cond_pass = w_n;
            4'b0101: w_cond_pass = ~w_n;
            4'b0110: w_cond_pass = w_v;
            4'b0111: w_cond_pass = ~w_v;
            4'b1000: w_cond_pass = w_c & ~w_z;
            4'b1001: w_cond_pass = ~w_c | w_z;
            4'b1010: w_cond_pass = (w_n == w_v);
            4'b1011: w_cond_pass = (w_n != w_v);
            4'b1100: w_cond_pass = ~w_z & (w_n == w_v);
            4'b1101: w_cond_pass = w_z | (w_n != w_v);
            4'b1110: w_cond_pass = 1'b1;
            default: w_cond_pass = 1'b0;
        endcase
    end

    // Reset suppresses every architectural side effect, even with an X flag register.
    assign CondEx   = w_cond_pass & ~reset;
    assign PCSrc    = PCS  & CondEx;
    assign RegWrite = RegW & CondEx;
    assign MemWrite = MemW & CondEx;
    assign Flags    = r_flags;

    // NZ and CV halves update independently, only when the instruction executes.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_flags <= 4'b0000;
        end else begin
            if (FlagW[1] & CondEx) r_flags[3:2] <= ALUFlags[3:2];
            if (FlagW[0] & CondEx) r_flags[1:0] <= ALUFlags[1:0];
        end
    end

`ifdef COND_LOGIC_PERF_EN
    logic [CNT_W-1:0] r_exec_cnt;
    logic [CNT_W-1:0] r_squash_cnt;

    // Every non-reset cycle bumps exactly one saturating counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_exec_cnt   <= '0;
            r_squash_cnt <= '0;
        end else if (CondEx) begin
            if (~&r_exec_cnt) r_exec_cnt <= r_exec_cnt + 1'b1;
        end else begin
            if (~&r_squash_cnt) r_squash_cnt <= r_squash_cnt + 1'b1;
        end
    end

    assign ExecCnt   = r_exec_cnt;
    assign SquashCnt = r_squash_cnt;
`endif

endmodule

// File: tb/tb_cond_logic.sv
// Self-checking bench for cond_logic: directed scenarios then randomized cycles vs a behavioural model.
// Checks are taken 1ns after inputs settle on the falling edge; the model advances at each rising edge.
// No backpressure in the DUT; the bench drives one instruction per cycle.
module tb_cond_logic;

    logic       clk;
    logic       reset;
    logic [3:0] cond;
    logic [3:0] alu_flags;
    logic [1:0] flag_w;
    logic       pcs;
    logic       reg_w;
    logic       mem_w;
    logic       pc_src;
    logic       reg_write;
    logic       mem_write;
    logic [3:0] flags;
    logic       cond_ex;
`ifdef COND_LOGIC_PERF_EN
    logic [3:0] exec_cnt;
    logic [3:0] squash_cnt;
`endif

    int checks;
    int errors;

    // Behavioural model state
    logic [3:0] m_flags;
    int         m_exec;
    int         m_squash;

    cond_logic #(.CNT_W(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .Cond     (cond),
        .ALUFlags (alu_flags),
        .FlagW    (flag_w),
        .PCS      (pcs),
        .RegW     (reg_w),
        .MemW     (mem_w),
        .PCSrc    (pc_src),
        .RegWrite (reg_write),
        .MemWrite (mem_write),
        .Flags    (flags),
        .CondEx   (cond_ex)
`ifdef COND_LOGIC_PERF_EN
        ,
        .ExecCnt  (exec_cnt),
        .SquashCnt(squash_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Condition table from the ISA, expressed on named flags.
    function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cf, v;
        n = f[3]; z = f[2]; cf = f[1]; v = f[0];
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cf;
            4'h3: return !cf;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cf && !z;
            4'h9: return !cf || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one instruction, check combinational outputs and state, then advance one clock.
    task automatic step(input string tag, input bit rst, input logic [3:0] c, input logic [3:0] alu,
                        input logic [1:0] fw, input bit p, input bit r, input bit m);
        bit ex;
        reset = rst; cond = c; alu_flags = alu; flag_w = fw; pcs = p; reg_w = r; mem_w = m;
        #1;
        ex = !rst && cond_ok(c, m_flags);
        chk({tag, ".CondEx"},   {31'b0, cond_ex},   {31'b0, ex});
        chk({tag, ".PCSrc"},    {31'b0, pc_src},    {31'b0, p && ex});
        chk({tag, ".RegWrite"}, {31'b0, reg_write}, {31'b0, r && ex});
        chk({tag, ".MemWrite"}, {31'b0, mem_write}, {31'b0, m && ex});
        chk({tag, ".Flags"},    {28'b0, flags},     {28'b0, m_flags});
`ifdef COND_LOGIC_PERF_EN
        chk({tag, ".ExecCnt"},   {28'b0, exec_cnt},   m_exec);
        chk({tag, ".SquashCnt"}, {28'b0, squash_cnt}, m_squash);
`endif
        @(posedge clk);
        if (rst) begin
            m_flags = 4'b0000; m_exec = 0; m_squash = 0;
        end else begin
            if (ex && fw[1]) m_flags[3:2] = alu[3:2];
            if (ex && fw[0]) m_flags[1:0] = alu[1:0];
            if (ex) m_exec = (m_exec < 15) ? m_exec + 1 : 15;
            else    m_squash = (m_squash < 15) ? m_squash + 1 : 15;
        end
        @(negedge clk);
    endtask

    initial begin
        checks = 0; errors = 0;
        m_flags = 4'b0000; m_exec = 0; m_squash = 0;
        reset = 1'b1; cond = 4'hE; alu_flags = 4'h0; flag_w = 2'b00;
        pcs = 1'b1; reg_w = 1'b1; mem_w = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset gating, then release
        step("rst_hold", 1, 4'hE, 4'h0, 2'b00, 1, 1, 1);
        chk("rst_flags_zero", {28'b0, flags}, 32'h0);
        step("rst_release", 0, 4'hE, 4'h0, 2'b00, 1, 1, 1);

        // Full flag set then EQ/NE
        step("set_z", 0, 4'hE, 4'b0100, 2'b11, 0, 0, 0);
        chk("set_z_flags", {28'b0, flags}, 32'h4);
        step("eq_after_set", 0, 4'h0, 4'h0, 2'b00, 0, 1, 0);
        chk("eq_regwrite", {31'b0, reg_write}, 32'h1);
        step("ne_after_set", 0, 4'h1, 4'h0, 2'b00, 0, 1, 0);

        // Partial update: only C,V taken
        step("partial", 0, 4'hE, 4'b1011, 2'b01, 0, 0, 0);
        chk("partial_flags", {28'b0, flags}, 32'h7);

        // Squashed flag setter
        step("sq_reset", 1, 4'hE, 4'h0, 2'b00, 0, 0, 0);
        step("sq_setter", 0, 4'h0, 4'hF, 2'b11, 0, 0, 1);
        step("sq_after", 0, 4'hE, 4'h0, 2'b00, 0, 0, 0);
        chk("sq_flags", {28'b0, flags}, 32'h0);

        // Signed conditions, N=V=1
        step("set_1001", 0, 4'hE, 4'b1001, 2'b11, 0, 0, 0);
        step("ge_1001", 0, 4'hA, 4'h0, 2'b00, 1, 1, 1);
        step("lt_1001", 0, 4'hB, 4'h0, 2'b00, 1, 1, 1);
        step("gt_1001", 0, 4'hC, 4'h0, 2'b00, 1, 1, 1);
        step("le_1001", 0, 4'hD, 4'h0, 2'b00, 1, 1, 1);
        // N=1, V=0
        step("set_1000", 0, 4'hE, 4'b1000, 2'b11, 0, 0, 0);
        step("ge_1000", 0, 4'hA, 4'h0, 2'b00, 1, 1, 1);
        step("lt_1000", 0, 4'hB, 4'h0, 2'b00, 1, 1, 1);
        step("le_1000", 0, 4'hD, 4'h0, 2'b00, 1, 1, 1);
        step("nv_never", 0, 4'hF, 4'h0, 2'b00, 1, 1, 1);

        // Performance counters: 5 executed then 3 squashed, then saturation and clear
        step("perf_reset", 1, 4'hE, 4'h0, 2'b00, 0, 0, 0);
        step("perf_al0", 0, 4'hE, 4'b0100, 2'b11, 0, 0, 0);
        for (int i = 1; i < 5; i++) step("perf_al", 0, 4'hE, 4'h0, 2'b00, 0, 0, 0);
        for (int i = 0; i < 3; i++) step("perf_ne", 0, 4'h1, 4'h0, 2'b00, 0, 0, 0);
`ifdef COND_LOGIC_PERF_EN
        chk("perf_exec5",   {28'b0, exec_cnt},   32'd5);
        chk("perf_squash3", {28'b0, squash_cnt}, 32'd3);
`endif
        for (int i = 0; i < 20; i++) step("perf_sat", 0, 4'hE, 4'h0, 2'b00, 0, 0, 0);
`ifdef COND_LOGIC_PERF_EN
        chk("perf_exec_sat", {28'b0, exec_cnt}, 32'd15);
`endif
        step("perf_clr", 1, 4'hE, 4'h0, 2'b00, 0, 0, 0);
`ifdef COND_LOGIC_PERF_EN
        chk("perf_clr_exec",   {28'b0, exec_cnt},   32'd0);
        chk("perf_clr_squash", {28'b0, squash_cnt}, 32'd0);
`endif

        // Randomized instruction stream with occasional reset
        for (int i = 0; i < 400; i++) begin
            step("rand", ($urandom_range(0, 15) == 0),
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
